// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32/RV64 immediate generator.
// One registered output stage plus one skid entry, valid/ready on both sides.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             in_zext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] ill_count
);

    localparam logic [2:0] F_I   = 3'd0;
    localparam logic [2:0] F_S   = 3'd1;
    localparam logic [2:0] F_B   = 3'd2;
    localparam logic [2:0] F_U   = 3'd3;
    localparam logic [2:0] F_J   = 3'd4;
    localparam logic [2:0] F_SH  = 3'd5;
    localparam logic [2:0] F_ILL = 3'd7;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            sgn;
    logic [XLEN-1:0] d_imm;
    logic [2:0]      d_fmt;
    logic            d_ill;
    logic [31:0]     raw;
    logic [5:0]      shamt;

    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic            skid_ill;

    logic            acc;
    logic            out_free;
    logic            skid_nxt;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign sgn = in_instr[31];

    // Shift amount is 5 bits on RV32 and 6 bits on RV64.
    assign shamt = (XLEN == 64) ? in_instr[25:20]
                                : {1'b0, in_instr[24:20]};

    // Decode the opcode into a format and a 32-bit signed immediate,
    // then widen; only the I-type zext and SHAMT rows zero-extend.
    always_comb begin
        raw   = 32'h0;
        d_imm = '0;
        d_fmt = F_ILL;
        d_ill = 1'b1;
        case (opc)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                d_ill = 1'b0;
                if (opc == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)) begin
                    d_fmt = F_SH;
                    d_imm = XLEN'(shamt);
                end else begin
                    d_fmt = F_I;
                    raw   = {{20{sgn}}, in_instr[31:20]};
                    d_imm = in_zext ? XLEN'(in_instr[31:20])
                                    : XLEN'($signed(raw));
                end
            end
            7'b0100011: begin
                d_ill = 1'b0;
                d_fmt = F_S;
                raw   = {{20{sgn}}, in_instr[31:25], in_instr[11:7]};
                d_imm = XLEN'($signed(raw));
            end
            7'b1100011: begin
                d_ill = 1'b0;
                d_fmt = F_B;
                raw   = {{19{sgn}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
                d_imm = XLEN'($signed(raw));
            end
            7'b0110111, 7'b0010111: begin
                d_ill = 1'b0;
                d_fmt = F_U;
                raw   = {in_instr[31:12], 12'h0};
                d_imm = XLEN'($signed(raw));
            end
            7'b1101111: begin
                d_ill = 1'b0;
                d_fmt = F_J;
                raw   = {{11{sgn}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
                d_imm = XLEN'($signed(raw));
            end
            default: begin
                d_ill = 1'b1;
                d_fmt = F_ILL;
                d_imm = '0;
            end
        endcase
    end

    // Handshake bookkeeping: output slot frees when empty or draining;
    // skid holds a result whenever the output slot cannot take it.
    always_comb begin
        acc      = in_valid & in_ready & ~flush;
        out_free = ~out_valid | out_ready;
        if (skid_valid) begin
            skid_nxt = out_free ? acc : 1'b1;
        end else begin
            skid_nxt = acc & ~out_free;
        end
    end

    // Output register and skid entry; skid drains first to keep order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
            skid_valid  <= 1'b0;
            skid_imm    <= '0;
            skid_fmt    <= '0;
            skid_ill    <= 1'b0;
            in_ready    <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            in_ready   <= ~skid_nxt;
            skid_valid <= skid_nxt;
            if (out_free) begin
                if (skid_valid) begin
                    out_valid   <= 1'b1;
                    out_imm     <= skid_imm;
                    out_fmt     <= skid_fmt;
                    out_illegal <= skid_ill;
                end else begin
                    out_valid <= acc;
                    if (acc) begin
                        out_imm     <= d_imm;
                        out_fmt     <= d_fmt;
                        out_illegal <= d_ill;
                    end
                end
            end
            if (acc && !(out_free && !skid_valid)) begin
                skid_imm <= d_imm;
                skid_fmt <= d_fmt;
                skid_ill <= d_ill;
            end
        end
    end

    // Saturating count of accepted illegal opcodes; survives flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ill_count <= '0;
        end else if (acc && d_ill && ill_count != '1) begin
            ill_count <= ill_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe.
// Two instances share stimulus: RV32/16-bit counter and RV64/2-bit counter.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_zext;
    logic        out_ready;

    logic        a_ready, a_valid, a_ill;
    logic [31:0] a_imm;
    logic [2:0]  a_fmt;
    logic [15:0] a_cnt;

    logic        b_ready, b_valid, b_ill;
    logic [63:0] b_imm;
    logic [2:0]  b_fmt;
    logic [1:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_ready),
        .in_instr(in_instr), .in_zext(in_zext),
        .out_valid(a_valid), .out_ready(out_ready),
        .out_imm(a_imm), .out_fmt(a_fmt),
        .out_illegal(a_ill), .ill_count(a_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_ready),
        .in_instr(in_instr), .in_zext(in_zext),
        .out_valid(b_valid), .out_ready(out_ready),
        .out_imm(b_imm), .out_fmt(b_fmt),
        .out_illegal(b_ill), .ill_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drv(input logic v, input logic [31:0] i, input logic z);
        in_valid = v;
        in_instr = i;
        in_zext  = z;
    endtask

    task automatic res(input string tag, input logic [31:0] imm,
                       input logic [2:0] fmt, input logic ill);
        chk({tag, "_v"}, 64'(a_valid), 64'd1);
        chk({tag, "_imm"}, 64'(a_imm), 64'(imm));
        chk({tag, "_fmt"}, 64'(a_fmt), 64'(fmt));
        chk({tag, "_ill"}, 64'(a_ill), 64'(ill));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drv(1'b0, 32'h0, 1'b0);
        repeat (3) cyc();
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_ready", 64'(a_ready), 64'd0);
        chk("rst_imm", 64'(a_imm), 64'd0);
        chk("rst_fmt", 64'(a_fmt), 64'd0);
        chk("rst_ill", 64'(a_ill), 64'd0);
        chk("rst_cnt", 64'(a_cnt), 64'd0);
        rst_n = 1'b1;
        cyc();
        chk("rel_ready", 64'(a_ready), 64'd1);
        chk("rel_valid", 64'(a_valid), 64'd0);

        drv(1'b1, 32'hFFF00093, 1'b0);
        cyc();
        res("addi_sext", 32'hFFFFFFFF, 3'd0, 1'b0);
        chk("addi_sext64", b_imm, 64'hFFFFFFFFFFFFFFFF);
        drv(1'b1, 32'hFFF00093, 1'b1);
        cyc();
        res("addi_zext", 32'h00000FFF, 3'd0, 1'b0);
        chk("addi_zext64", b_imm, 64'h0000000000000FFF);
        drv(1'b0, 32'h0, 1'b0);
        cyc();
        chk("idle_valid", 64'(a_valid), 64'd0);

        drv(1'b1, 32'hFE112E23, 1'b1);
        cyc();
        res("sw", 32'hFFFFFFFC, 3'd1, 1'b0);
        chk("sw64", b_imm, 64'hFFFFFFFFFFFFFFFC);
        drv(1'b1, 32'h12345037, 1'b0);
        cyc();
        res("lui", 32'h12345000, 3'd3, 1'b0);
        drv(1'b1, 32'hFFDFF06F, 1'b0);
        cyc();
        res("jal", 32'hFFFFFFFC, 3'd4, 1'b0);
        chk("jal64", b_imm, 64'hFFFFFFFFFFFFFFFC);
        drv(1'b1, 32'h01F09093, 1'b1);
        cyc();
        res("slli31", 32'h0000001F, 3'd5, 1'b0);
        chk("stream_ready", 64'(a_ready), 64'd1);
        drv(1'b1, 32'hFE000EE3, 1'b0);
        cyc();
        res("beq", 32'hFFFFFFFC, 3'd2, 1'b0);
        drv(1'b0, 32'h0, 1'b0);
        cyc();

        out_ready = 1'b0;
        drv(1'b1, 32'h00500093, 1'b0);
        cyc();
        res("stall_a", 32'h00000005, 3'd0, 1'b0);
        chk("stall_rdy1", 64'(a_ready), 64'd1);
        drv(1'b1, 32'hABCDE037, 1'b0);
        cyc();
        chk("stall_rdy2", 64'(a_ready), 64'd0);
        res("stall_hold1", 32'h00000005, 3'd0, 1'b0);
        drv(1'b1, 32'h00700093, 1'b0);
        cyc();
        chk("stall_rdy3", 64'(a_ready), 64'd0);
        res("stall_hold2", 32'h00000005, 3'd0, 1'b0);
        drv(1'b0, 32'h0, 1'b0);
        out_ready = 1'b1;
        cyc();
        res("stall_b", 32'hABCDE000, 3'd3, 1'b0);
        chk("stall_b64", b_imm, 64'hFFFFFFFFABCDE000);
        chk("stall_rdy4", 64'(a_ready), 64'd1);
        cyc();
        chk("stall_drop_c", 64'(a_valid), 64'd0);

        for (int k = 1; k <= 4; k++) begin
            drv(1'b1, 32'h00000000, 1'b0);
            cyc();
            res($sformatf("ill%0d", k), 32'h0, 3'd7, 1'b1);
            chk($sformatf("ill%0d_cnt", k), 64'(a_cnt), 64'(k));
            chk($sformatf("ill%0d_cnt2", k), 64'(b_cnt),
                64'((k > 3) ? 3 : k));
        end
        drv(1'b0, 32'h0, 1'b0);
        cyc();

        out_ready = 1'b0;
        drv(1'b1, 32'h00100093, 1'b0);
        cyc();
        drv(1'b1, 32'h00200093, 1'b0);
        cyc();
        chk("full_ready", 64'(a_ready), 64'd0);
        drv(1'b1, 32'h00000000, 1'b0);
        flush = 1'b1;
        cyc();
        chk("flush_valid", 64'(a_valid), 64'd0);
        chk("flush_ready", 64'(a_ready), 64'd1);
        chk("flush_cnt", 64'(a_cnt), 64'd4);
        cyc();
        chk("flush_drop_v", 64'(a_valid), 64'd0);
        chk("flush_drop_cnt", 64'(a_cnt), 64'd4);
        flush = 1'b0;
        drv(1'b0, 32'h0, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk("flush_empty", 64'(a_valid), 64'd0);

        drv(1'b1, 32'h80000037, 1'b0);
        cyc();
        chk("lui64", b_imm, 64'hFFFFFFFF80000000);
        chk("lui64_fmt", 64'(b_fmt), 64'd3);
        res("lui32", 32'h80000000, 3'd3, 1'b0);
        drv(1'b1, 32'h03F09093, 1'b0);
        cyc();
        chk("slli63_64", b_imm, 64'h000000000000003F);
        chk("slli63_64fmt", 64'(b_fmt), 64'd5);
        res("slli63_32", 32'h0000001F, 3'd5, 1'b0);
        drv(1'b0, 32'h0, 1'b0);
        cyc();

        out_ready = 1'b0;
        drv(1'b1, 32'h00300093, 1'b0);
        cyc();
        drv(1'b1, 32'h00400093, 1'b0);
        cyc();
        drv(1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        cyc();
        chk("mrst_valid", 64'(a_valid), 64'd0);
        chk("mrst_ready", 64'(a_ready), 64'd0);
        chk("mrst_cnt", 64'(a_cnt), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("mrst_rel_v", 64'(a_valid), 64'd0);
        chk("mrst_rel_rdy", 64'(a_ready), 64'd1);
        cyc();
        chk("mrst_nostale", 64'(a_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
